// File: rtl/aes_pkg.sv
// Shared types for the iterative AES round sequencer: datapath mode encoding,
// sequencer states and the AES block width.
package aes_pkg;
   typedef enum logic [1:0] {
      DP_INIT  = 2'b00,
      DP_FULL  = 2'b01,
      DP_FINAL = 2'b10
   } dp_mode_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ROUND,
      S_DONE
   } seq_state_t;

   localparam int AES_BLK_W = 128;
endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption sequencer: holds the 128-bit state and steps it through
// the initial AddRoundKey, the full rounds and the final round via an external datapath.
module aes_round_sequencer
   import aes_pkg::*;
#(
   parameter  int NUM_ROUNDS = 10,
   localparam int RW         = $clog2(NUM_ROUNDS + 1)
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 abort,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [AES_BLK_W-1:0] in_data,
   output logic                 key_req,
   output logic [RW-1:0]        key_rnd,
   input  logic                 key_ack,
   output logic [1:0]           dp_mode,
   output logic [AES_BLK_W-1:0] dp_in,
   input  logic [AES_BLK_W-1:0] dp_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [AES_BLK_W-1:0] out_data,
   output logic                 busy
);

   localparam logic [RW-1:0] LAST    = RW'(NUM_ROUNDS);
   localparam logic [RW-1:0] LAST_M1 = RW'(NUM_ROUNDS - 1);

   seq_state_t           r_seq;
   logic [RW-1:0]        r_rnd;
   logic [AES_BLK_W-1:0] r_state;
   logic                 r_in_ready;
   logic                 r_key_req;
   dp_mode_t             r_dp_mode;
   logic                 r_out_valid;
   logic                 r_busy;

   // Outputs are registered alongside the state: each transition loads the
   // output values belonging to the state being entered.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_seq       <= S_IDLE;
         r_rnd       <= '0;
         r_state     <= '0;
         r_in_ready  <= 1'b1;
         r_key_req   <= 1'b0;
         r_dp_mode   <= DP_INIT;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else if (abort) begin
         r_seq       <= S_IDLE;
         r_rnd       <= '0;
         r_state     <= '0;
         r_in_ready  <= 1'b1;
         r_key_req   <= 1'b0;
         r_dp_mode   <= DP_INIT;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_seq)
            S_IDLE: begin
               if (in_valid) begin
                  r_seq      <= S_ROUND;
                  r_state    <= in_data;
                  r_rnd      <= '0;
                  r_in_ready <= 1'b0;
                  r_key_req  <= 1'b1;
                  r_dp_mode  <= DP_INIT;
                  r_busy     <= 1'b1;
               end
            end
            S_ROUND: begin
               if (key_ack) begin
                  r_state <= dp_out;
                  if (r_rnd == LAST) begin
                     r_seq       <= S_DONE;
                     r_key_req   <= 1'b0;
                     r_dp_mode   <= DP_INIT;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_rnd     <= r_rnd + 1'b1;
                     r_dp_mode <= (r_rnd == LAST_M1) ? DP_FINAL : DP_FULL;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_seq       <= S_IDLE;
                  r_rnd       <= '0;
                  r_in_ready  <= 1'b1;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_seq <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign key_req   = r_key_req;
   assign key_rnd   = r_rnd;
   assign dp_mode   = r_dp_mode;
   assign dp_in     = r_state;
   assign out_data  = r_state;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer with a behavioural AES round datapath
// and AES-128 key schedule standing in for the parent-level blocks.
module tb_aes_round_sequencer;

   logic         clk = 1'b0;
   logic         n_rst;
   logic         abort;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         key_req;
   logic [3:0]   key_rnd;
   logic         key_ack;
   logic [1:0]   dp_mode;
   logic [127:0] dp_in;
   logic [127:0] dp_out;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;

   int checks = 0;
   int errors = 0;

   logic [7:0]   sb [0:255];
   logic [127:0] rk [0:15];

   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

   aes_round_sequencer #(.NUM_ROUNDS(10)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .key_req   (key_req),
      .key_rnd   (key_rnd),
      .key_ack   (key_ack),
      .dp_mode   (dp_mode),
      .dp_in     (dp_in),
      .dp_out    (dp_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] a);
      logic [7:0] inv = 8'h01;
      if (a == 8'h00) inv = 8'h00;
      else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] aes_rnd(input logic [127:0] st, input logic [1:0] mode,
                                             input logic [127:0] k);
      logic [7:0]   a [0:15];
      logic [7:0]   b [0:15];
      logic [7:0]   c0, c1, c2, c3;
      logic [127:0] r;
      for (int i = 0; i < 16; i++) a[i] = st[127-8*i -: 8];
      for (int row = 0; row < 4; row++)
         for (int col = 0; col < 4; col++)
            b[row+4*col] = sb[a[row+4*((col+row)%4)]];
      if (mode == 2'b01) begin
         for (int col = 0; col < 4; col++) begin
            c0 = b[4*col]; c1 = b[4*col+1]; c2 = b[4*col+2]; c3 = b[4*col+3];
            b[4*col]   = gmul(c0, 8'h02) ^ gmul(c1, 8'h03) ^ c2 ^ c3;
            b[4*col+1] = c0 ^ gmul(c1, 8'h02) ^ gmul(c2, 8'h03) ^ c3;
            b[4*col+2] = c0 ^ c1 ^ gmul(c2, 8'h02) ^ gmul(c3, 8'h03);
            b[4*col+3] = gmul(c0, 8'h03) ^ c1 ^ c2 ^ gmul(c3, 8'h02);
         end
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
      return (mode == 2'b00) ? (st ^ k) : (r ^ k);
   endfunction

   task automatic set_key(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
            rcon = xt(rcon);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 16; r++) rk[r] = '0;
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   always_comb dp_out = aes_rnd(dp_in, dp_mode, rk[key_rnd]);

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_key_req"}, key_req, 0);
      check({tag, "_key_rnd"}, key_rnd, 0);
   endtask

   // Offers one block, acks keys (optionally stalling before rounds 0, 5, 10),
   // traces key_rnd/dp_mode per round and stops at the first out_valid cycle.
   task automatic run_block(input logic [127:0] pt, input logic [127:0] ct,
                            input bit stall, input int exp_lat);
      int cyc = 0;
      int exp_rnd = 0;
      int wait_n = stall ? 3 : 0;
      bit seen = 0;
      @(negedge clk);
      check("accept_in_ready", in_ready, 1);
      in_data  = pt;
      in_valid = 1'b1;
      key_ack  = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 80 && !seen; i++) begin
         @(negedge clk);
         cyc++;
         in_valid = 1'b0;
         if (out_valid) begin
            seen = 1;
         end else begin
            check("round_key_req", key_req, 1);
            check("round_key_rnd", key_rnd, exp_rnd);
            check("round_dp_mode", dp_mode, (exp_rnd == 0) ? 2'b00 :
                                            (exp_rnd == 10) ? 2'b10 : 2'b01);
            check("round_in_ready", in_ready, 0);
            key_ack = (wait_n == 0);
            if (wait_n > 0) wait_n--;
            if (key_ack) begin
               exp_rnd++;
               if (stall && (exp_rnd == 5 || exp_rnd == 10)) wait_n = 3;
            end
         end
      end
      key_ack = 1'b0;
      check("latency", cyc, exp_lat);
      check("ciphertext", out_data, ct);
      check("done_dp_in", dp_in, ct);
      check("done_in_ready", in_ready, 0);
      check("done_key_req", key_req, 0);
      check("done_busy", busy, 1);
   endtask

   task automatic finish_block(input logic [127:0] ct, input int hold);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_out_valid", out_valid, 1);
         check("hold_out_data", out_data, ct);
         check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_idle("post_done");
   endtask

   task automatic start_block(input logic [127:0] pt);
      @(negedge clk);
      in_data  = pt;
      in_valid = 1'b1;
      key_ack  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_rnd(input int n);
      bit found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (key_rnd == n) found = 1;
      end
      check("wait_rnd", found, 1);
   endtask

   initial begin
      n_rst = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
      key_ack = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
      set_key(KEY_C1);
      #12;
      check_idle("reset");
      check("reset_dp_mode", dp_mode, 2'b00);
      check("reset_out_data", out_data, 0);
      check("reset_dp_in", dp_in, 0);
      @(negedge clk);
      n_rst = 1'b1;

      run_block(PT_C1, CT_C1, 1'b0, 12);
      finish_block(CT_C1, 4);

      run_block(PT_C1, CT_C1, 1'b1, 21);
      finish_block(CT_C1, 0);

      start_block(PT_C1);
      wait_rnd(6);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      key_ack = 1'b0;
      check_idle("abort");
      check("abort_state", dp_in, 0);
      @(negedge clk);
      check("abort_no_valid", out_valid, 0);
      abort = 1'b1;
      in_valid = 1'b1;
      in_data = PT_B;
      @(negedge clk);
      abort = 1'b0;
      in_valid = 1'b0;
      check_idle("abort_idle");
      check("abort_not_loaded", dp_in, 0);
      run_block(PT_C1, CT_C1, 1'b0, 12);
      finish_block(CT_C1, 1);

      start_block(PT_C1);
      wait_rnd(3);
      #2 n_rst = 1'b0;
      #1;
      key_ack = 1'b0;
      check_idle("rst_mid");
      check("rst_mid_dp_mode", dp_mode, 2'b00);
      check("rst_mid_out_data", out_data, 0);
      @(negedge clk);
      n_rst = 1'b1;
      set_key(KEY_B);
      run_block(PT_B, CT_B, 1'b0, 12);
      finish_block(CT_B, 0);
      run_block(PT_B, CT_B, 1'b0, 12);
      finish_block(CT_B, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
